// File: rtl/cfg_pwm_timer.sv
// Prescaled timer/PWM generator configured from a flat register vector; status returned from flops.
// Latency: EN rising edge gives RUNNING=1, counter=0 one clock later; pwm_out/irq registered, aligned with ST0/ST1.
// Backpressure: none; ena=0 freezes every flop, including the edge detectors and outputs.
module cfg_pwm_timer #(
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter int REG_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ena,
    input  logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    output logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
    output logic                            pwm_out,
    output logic                            irq
);

    localparam int W = REG_WIDTH;
    localparam logic [W-1:0] ONE = W'(1);

    // Config fields (registers above CFG3 and upper CFG0 bits carry nothing for this block)
    logic         cfg_en;
    logic         cfg_oneshot;
    logic         cfg_irq_en;
    logic         cfg_clr;
    logic [W-1:0] cfg_presc;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_duty;
    logic         unused_cfg;

    assign cfg_en      = config_regs[0];
    assign cfg_oneshot = config_regs[1];
    assign cfg_irq_en  = config_regs[2];
    assign cfg_clr     = config_regs[3];
    assign cfg_presc   = config_regs[1*W +: W];
    assign cfg_period  = config_regs[2*W +: W];
    assign cfg_duty    = config_regs[3*W +: W];
    assign unused_cfg  = ^config_regs;

    // State
    logic [W-1:0] counter;
    logic [W-1:0] presc_cnt;
    logic [W-1:0] wrap_cnt;
    logic         running;
    logic         wrap_flag;
    logic         done;
    logic         en_q;
    logic         clr_q;

    // Next-state values
    logic [W-1:0] cnt_nxt;
    logic [W-1:0] presc_nxt;
    logic [W-1:0] wc_nxt;
    logic         run_nxt;
    logic         done_nxt;
    logic         wrap_nxt;
    logic         wrap_hit;
    logic         clr_rise;

    // Next-state: EN level/edge handling, prescaler tick, counter wrap, and wrap-flag clear
    always_comb begin
        cnt_nxt   = counter;
        presc_nxt = presc_cnt;
        wc_nxt    = wrap_cnt;
        run_nxt   = running;
        done_nxt  = done;
        wrap_hit  = 1'b0;
        clr_rise  = cfg_clr & ~clr_q;
        if (!cfg_en) begin
            run_nxt   = 1'b0;
            cnt_nxt   = '0;
            presc_nxt = '0;
        end else if (!en_q) begin
            run_nxt   = 1'b1;
            cnt_nxt   = '0;
            presc_nxt = '0;
            done_nxt  = 1'b0;
        end else if (running) begin
            if (presc_cnt == cfg_presc) begin
                presc_nxt = '0;
                // >= so that lowering PERIOD below the current count forces a wrap
                if (counter >= cfg_period) begin
                    cnt_nxt  = '0;
                    wrap_hit = 1'b1;
                    wc_nxt   = wrap_cnt + ONE;
                    if (cfg_oneshot) begin
                        run_nxt  = 1'b0;
                        done_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = counter + ONE;
                end
            end else begin
                presc_nxt = presc_cnt + ONE;
            end
        end
        // A wrap in the same cycle as a CLR edge wins
        wrap_nxt = wrap_hit | (wrap_flag & ~clr_rise);
    end

    // State and output registers; everything holds while ena is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter   <= '0;
            presc_cnt <= '0;
            wrap_cnt  <= '0;
            running   <= 1'b0;
            wrap_flag <= 1'b0;
            done      <= 1'b0;
            en_q      <= 1'b0;
            clr_q     <= 1'b0;
            pwm_out   <= 1'b0;
            irq       <= 1'b0;
        end else if (ena) begin
            counter   <= cnt_nxt;
            presc_cnt <= presc_nxt;
            wrap_cnt  <= wc_nxt;
            running   <= run_nxt;
            wrap_flag <= wrap_nxt;
            done      <= done_nxt;
            en_q      <= cfg_en;
            clr_q     <= cfg_clr;
            pwm_out   <= run_nxt & (cnt_nxt < cfg_duty);
            irq       <= cfg_irq_en & wrap_nxt;
        end
    end

    // Status readback, sourced only from flops
    always_comb begin
        status_regs          = '0;
        status_regs[0 +: W]  = counter;
        status_regs[W +: W]  = {{(W-3){1'b0}}, done, wrap_flag, running};
        status_regs[2*W +: W] = wrap_cnt;
    end

endmodule
